// File: rtl/histo_pkg.sv
// Shared definitions for the histogram bin RAM: default widths, clear FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package histo_pkg;

  localparam int ADDR_W_DEF = 10;  // bin address width, DEPTH = 2**ADDR_W
  localparam int DATA_W_DEF = 32;  // bin counter width
  localparam int DROP_W     = 16;  // width of the dropped-increment counter

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } clrState_t;

endpackage

// File: rtl/histo_ram_core.sv
// Plain 1W/2R synchronous RAM, old data returned on read-during-write.
// Latency: 1 cycle per read port; read registers hold when their enable is low.
// Backpressure: none, every request is serviced in the cycle it is presented.
//
// Ports: Clock/Reset_n (reset touches only the read registers),
//        WrEn/WrAddr/WrData write port, RdEnA/RdAddrA/RdDataA and
//        RdEnB/RdAddrB/RdDataB independent synchronous read ports.
module histo_ram_core
  import histo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [DATA_W-1:0] RdDataA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataB
);

  localparam int DEPTH = 1 << ADDR_W;

  // Memory array is deliberately unreset; contents are defined by a clear sweep.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (WrEn) mem[WrAddr] <= WrData;
  end

  // Non-blocking update of mem means a same-edge read sees the old word.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      RdDataA <= '0;
      RdDataB <= '0;
    end else begin
      if (RdEnA) RdDataA <= mem[RdAddrA];
      if (RdEnB) RdDataB <= mem[RdAddrB];
    end
  end

endmodule

// File: rtl/histo_bin_ram.sv
// Histogram bin RAM: pipelined increment port, direct write/read ports, clear sweep.
// Latency: increment commits 2 edges after acceptance; read data 1 cycle after RdEn.
// Backpressure: WrReady low while increments are in flight or clear busy; increments dropped (counted) while busy.
//
// Ports: IncEn/IncAddress increment request; WE/WrClockEn/WrAddress/Data/WrReady
//        direct write; RdEn/RdAddress/Q/RdValid readout; ClearStart/Busy/ClearDone
//        clear control; SatFlag sticky saturation flag; DropCnt dropped increments.
module histo_bin_ram
  import histo_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              IncEn,
  input  logic [ADDR_W-1:0] IncAddress,
  input  logic              WE,
  input  logic              WrClockEn,
  input  logic [ADDR_W-1:0] WrAddress,
  input  logic [DATA_W-1:0] Data,
  output logic              WrReady,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddress,
  output logic [DATA_W-1:0] Q,
  output logic              RdValid,
  input  logic              ClearStart,
  output logic              Busy,
  output logic              ClearDone,
  output logic              SatFlag,
  output logic [DROP_W-1:0] DropCnt
);

  clrState_t         state, stateNext;
  logic [ADDR_W-1:0] sweepAddr;
  logic              runQ;

  logic              s1Vld, s2Vld, s3Vld;
  logic [ADDR_W-1:0] s1Addr, s2Addr, s3Addr;
  logic [DATA_W-1:0] s2Data, s3Data, s2New, ramA;

  logic              incAccept, incDrop, wrAccept;
  logic              ramWrEn;
  logic [ADDR_W-1:0] ramWrAddr;
  logic [DATA_W-1:0] ramWrData;

  // Increments are only taken in IDLE and not on the cycle a clear is requested.
  assign incAccept = IncEn & (state == IDLE) & ~ClearStart;
  assign incDrop   = IncEn & ~incAccept;

  // runQ keeps WrReady low while reset is asserted.
  assign WrReady  = runQ & (state == IDLE) & ~IncEn & ~s1Vld & ~s2Vld;
  assign wrAccept = WE & WrClockEn & WrReady;

  assign s2New = (SATURATE && (&s2Data)) ? s2Data : s2Data + 1'b1;

  histo_ram_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uRam (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .WrEn    (ramWrEn),
    .WrAddr  (ramWrAddr),
    .WrData  (ramWrData),
    .RdEnA   (incAccept),
    .RdAddrA (IncAddress),
    .RdDataA (ramA),
    .RdEnB   (RdEn),
    .RdAddrB (RdAddress),
    .RdDataB (Q)
  );

  // Single write port: increment write-back, then sweep, then direct write.
  // The latter two can only occur with an empty increment pipe anyway.
  always_comb begin
    ramWrEn   = 1'b0;
    ramWrAddr = s2Addr;
    ramWrData = s2New;
    if (s2Vld) begin
      ramWrEn = 1'b1;
    end else if (state == SWEEP) begin
      ramWrEn   = 1'b1;
      ramWrAddr = sweepAddr;
      ramWrData = '0;
    end else if (wrAccept) begin
      ramWrEn   = 1'b1;
      ramWrAddr = WrAddress;
      ramWrData = Data;
    end
  end

  // Increment pipeline. The RAM read for S1 is sampled on the same edge that
  // S2's predecessor (now S3) writes, and old-data semantics hide that write,
  // so S3 is forwarded as well as S2. S2 is newer and takes priority.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1Vld  <= 1'b0;
      s1Addr <= '0;
      s2Vld  <= 1'b0;
      s2Addr <= '0;
      s2Data <= '0;
      s3Vld  <= 1'b0;
      s3Addr <= '0;
      s3Data <= '0;
    end else begin
      s1Vld  <= incAccept;
      s1Addr <= IncAddress;
      s2Vld  <= s1Vld;
      s2Addr <= s1Addr;
      if (s2Vld && (s2Addr == s1Addr))      s2Data <= s2New;
      else if (s3Vld && (s3Addr == s1Addr)) s2Data <= s3Data;
      else                                  s2Data <= ramA;
      s3Vld  <= s2Vld;
      s3Addr <= s2Addr;
      s3Data <= s2New;
    end
  end

  // Clear FSM state register and sweep address.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      sweepAddr <= '0;
    end else begin
      state     <= stateNext;
      sweepAddr <= (state == SWEEP) ? sweepAddr + 1'b1 : '0;
    end
  end

  always_comb begin
    stateNext = state;
    Busy      = 1'b1;
    ClearDone = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (ClearStart) stateNext = DRAIN;
      end
      DRAIN: if (!s1Vld && !s2Vld) stateNext = SWEEP;
      SWEEP: if (&sweepAddr) stateNext = DONE;
      DONE: begin
        ClearDone = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Status: read valid, sticky saturation, dropped-increment counter.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      runQ    <= 1'b0;
      RdValid <= 1'b0;
      SatFlag <= 1'b0;
      DropCnt <= '0;
    end else begin
      runQ    <= 1'b1;
      RdValid <= RdEn;
      if (state == DONE)                        SatFlag <= 1'b0;
      else if (SATURATE && s2Vld && (&s2Data))  SatFlag <= 1'b1;
      if (incDrop && (DropCnt != '1)) DropCnt <= DropCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_histo_bin_ram.sv
// Directed bench for histo_bin_ram: a saturating and a wrapping instance share stimulus.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_histo_bin_ram;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              IncEn, WE, WrClockEn, RdEn, ClearStart;
  logic [ADDR_W-1:0] IncAddress, WrAddress, RdAddress;
  logic [DATA_W-1:0] Data;

  logic              WrReady, RdValid, Busy, ClearDone, SatFlag;
  logic [DATA_W-1:0] Q;
  logic [15:0]       DropCnt;

  logic              WrReadyW, RdValidW, BusyW, ClearDoneW, SatFlagW;
  logic [DATA_W-1:0] QW;
  logic [15:0]       DropCntW;

  int assertCnt = 0;
  int failCnt   = 0;

  always #5 Clock = ~Clock;

  histo_bin_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SATURATE(1'b1)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .IncEn(IncEn), .IncAddress(IncAddress),
    .WE(WE), .WrClockEn(WrClockEn), .WrAddress(WrAddress), .Data(Data), .WrReady(WrReady),
    .RdEn(RdEn), .RdAddress(RdAddress), .Q(Q), .RdValid(RdValid),
    .ClearStart(ClearStart), .Busy(Busy), .ClearDone(ClearDone),
    .SatFlag(SatFlag), .DropCnt(DropCnt)
  );

  histo_bin_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SATURATE(1'b0)) dutW (
    .Clock(Clock), .Reset_n(Reset_n),
    .IncEn(IncEn), .IncAddress(IncAddress),
    .WE(WE), .WrClockEn(WrClockEn), .WrAddress(WrAddress), .Data(Data), .WrReady(WrReadyW),
    .RdEn(RdEn), .RdAddress(RdAddress), .Q(QW), .RdValid(RdValidW),
    .ClearStart(ClearStart), .Busy(BusyW), .ClearDone(ClearDoneW),
    .SatFlag(SatFlagW), .DropCnt(DropCntW)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic rdBin(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] q, output logic [DATA_W-1:0] qw);
    RdEn      = 1'b1;
    RdAddress = a;
    tick();
    RdEn = 1'b0;
    checkVal("rd_valid", {31'd0, RdValid}, 32'd1);
    q  = Q;
    qw = QW;
  endtask

  task automatic incBurst(input logic [ADDR_W-1:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      IncEn      = 1'b1;
      IncAddress = a;
      tick();
    end
    IncEn = 1'b0;
    repeat (3) tick();
  endtask

  // Waits for ClearDone after a clear has been launched; n counts edges since ClearStart.
  task automatic waitDone(inout int n);
    while (!ClearDone && n < 3000) begin
      tick();
      n++;
    end
    checkVal("clr_done_seen", {31'd0, ClearDone}, 32'd1);
    tick();
  endtask

  initial begin
    logic [DATA_W-1:0] q, qw;
    int n, pulses;

    Reset_n = 1'b0; IncEn = 1'b0; WE = 1'b0; WrClockEn = 1'b0; RdEn = 1'b0; ClearStart = 1'b0;
    IncAddress = '0; WrAddress = '0; RdAddress = '0; Data = '0;
    repeat (3) tick();

    // Reset state
    checkVal("rst_q",        Q,                     32'd0);
    checkVal("rst_rdvalid",  {31'd0, RdValid},      32'd0);
    checkVal("rst_wrready",  {31'd0, WrReady},      32'd0);
    checkVal("rst_busy",     {31'd0, Busy},         32'd0);
    checkVal("rst_cleardone",{31'd0, ClearDone},    32'd0);
    checkVal("rst_satflag",  {31'd0, SatFlag},      32'd0);
    checkVal("rst_dropcnt",  {16'd0, DropCnt},      32'd0);
    Reset_n = 1'b1;
    tick();
    checkVal("idle_wrready", {31'd0, WrReady}, 32'd1);

    // Clear latency and full read-back
    ClearStart = 1'b1;
    tick();
    ClearStart = 1'b0;
    n = 1;
    checkVal("clr_busy", {31'd0, Busy}, 32'd1);
    waitDone(n);
    checkVal("clr_latency", n, DEPTH + 2);
    checkVal("clr_busy_end", {31'd0, Busy}, 32'd0);
    checkVal("clr_done_pulse", {31'd0, ClearDone}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rdBin(i[ADDR_W-1:0], q, qw);
      checkVal("clr_bin", q, 32'd0);
    end
    tick();
    checkVal("rdvalid_low", {31'd0, RdValid}, 32'd0);

    // Back-to-back increments to one bin
    incBurst(10'd5, 100);
    rdBin(10'd5, q, qw); checkVal("b2b_bin5", q, 32'd100);
    tick();
    checkVal("q_hold", Q, 32'd100);
    rdBin(10'd4, q, qw); checkVal("b2b_bin4", q, 32'd0);
    rdBin(10'd6, q, qw); checkVal("b2b_bin6", q, 32'd0);

    // Alternating bins exercise distance-2 hazards
    for (int i = 0; i < 10; i++) begin
      IncEn      = 1'b1;
      IncAddress = (i % 2 == 0) ? 10'd3 : 10'd7;
      tick();
    end
    IncEn = 1'b0;
    repeat (3) tick();
    rdBin(10'd3, q, qw); checkVal("alt_bin3", q, 32'd5);
    rdBin(10'd7, q, qw); checkVal("alt_bin7", q, 32'd5);

    // Write without WrClockEn must not land
    WE = 1'b1; WrClockEn = 1'b0; WrAddress = 10'd21; Data = 32'h55;
    tick();
    WE = 1'b0;
    rdBin(10'd21, q, qw); checkVal("wr_gated", q, 32'd0);

    // Write held through an increment burst; ready 2 cycles after last IncEn
    WE = 1'b1; WrClockEn = 1'b1; WrAddress = 10'd20; Data = 32'hABCD; IncAddress = 10'd30;
    for (int c = 0; c < 8; c++) begin
      IncEn = (c < 5);
      #1;
      checkVal($sformatf("arb_wrready_c%0d", c), {31'd0, WrReady}, (c >= 7) ? 32'd1 : 32'd0);
      @(posedge Clock);
      #1;
    end
    WE = 1'b0; WrClockEn = 1'b0; IncEn = 1'b0;
    rdBin(10'd20, q, qw); checkVal("arb_wr_bin20", q, 32'hABCD);
    rdBin(10'd30, q, qw); checkVal("arb_inc_bin30", q, 32'd5);

    // Saturation vs wrap
    WE = 1'b1; WrClockEn = 1'b1; WrAddress = 10'd9; Data = 32'hFFFF_FFFE;
    #1;
    checkVal("sat_wrready", {31'd0, WrReady}, 32'd1);
    tick();
    WE = 1'b0; WrClockEn = 1'b0;
    incBurst(10'd9, 3);
    rdBin(10'd9, q, qw);
    checkVal("sat_bin9",  q,  32'hFFFF_FFFF);
    checkVal("wrap_bin9", qw, 32'd1);
    checkVal("sat_flag",  {31'd0, SatFlag},  32'd1);
    checkVal("wrap_flag", {31'd0, SatFlagW}, 32'd0);

    // Clear overlapped with increments: all 4 dropped, SatFlag cleared
    ClearStart = 1'b1; IncEn = 1'b1; IncAddress = 10'd40;
    tick();
    ClearStart = 1'b0;
    repeat (3) tick();
    IncEn = 1'b0;
    checkVal("drop_cnt",  {16'd0, DropCnt},  32'd4);
    checkVal("drop_cntw", {16'd0, DropCntW}, 32'd4);
    n = 4;
    waitDone(n);
    checkVal("clr2_satflag", {31'd0, SatFlag}, 32'd0);
    rdBin(10'd40, q, qw); checkVal("clr2_bin40", q, 32'd0);
    rdBin(10'd9,  q, qw); checkVal("clr2_bin9",  q, 32'd0); checkVal("clr2_bin9w", qw, 32'd0);
    rdBin(10'd20, q, qw); checkVal("clr2_bin20", q, 32'd0);
    rdBin(10'd5,  q, qw); checkVal("clr2_bin5",  q, 32'd0);
    checkVal("drop_cnt_kept", {16'd0, DropCnt}, 32'd4);

    // Reset in the middle of a sweep
    ClearStart = 1'b1;
    tick();
    ClearStart = 1'b0;
    repeat (50) tick();
    checkVal("mid_busy", {31'd0, Busy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    checkVal("mid_rst_busy",    {31'd0, Busy},    32'd0);
    checkVal("mid_rst_dropcnt", {16'd0, DropCnt}, 32'd0);
    repeat (2) tick();
    Reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < DEPTH + 50; i++) begin
      tick();
      if (ClearDone) pulses++;
    end
    checkVal("mid_no_done", pulses, 32'd0);
    checkVal("mid_idle_busy", {31'd0, Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
